// File: rtl/simple_dma_rd.sv
// simple_dma_rd: streams len bytes from base out of a fixed-latency memory.
// Credit-gated issue, in-flight tracker, head register plus ring buffer.
module simple_dma_rd #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base,
  input  logic [15:0] len,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  input  logic        pix_ready,
  output logic [15:0] bytes_read,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     base_q, len_q, off_q;
  logic [15:0]     addr_d;
  logic [RD_LAT-1:0] sr_q;
  logic [CW-1:0]   cnt_q, infl_q;
  logic [AW-1:0]   wp_q, rp_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            head_v_q;
  logic [7:0]      head_q;
  logic            issue, done_d;
  logic            push, pop, hd_free;
  logic            buf_in, buf_out;
  logic            credit, last_hs;

  assign push    = sr_q[RD_LAT-1];
  assign pop     = head_v_q && pix_ready;
  assign hd_free = !head_v_q || pop;
  assign buf_in  = push && !(hd_free && cnt_q == '0);
  assign buf_out = hd_free && cnt_q != '0;
  assign credit  = (cnt_q + infl_q) < CW'(FIFO_DEPTH);
  assign last_hs = (state_q == DRAIN) && pop &&
                   (bytes_read == len_q - 16'd1);

  assign busy      = (state_q != IDLE);
  assign pix_valid = head_v_q;
  assign pix_data  = head_q;

  // Next state, read issue and completion decision
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    addr_d  = base_q + off_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            issue   = 1'b1;
            addr_d  = base;
            state_d = (len == 16'd1) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (off_q + 16'd1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Transfer control: latched params, issue offset, strobes, byte count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      done       <= 1'b0;
      bytes_read <= '0;
    end else begin
      rd_en <= issue;
      done  <= done_d;
      if (issue) rd_addr <= addr_d;
      if (state_q == IDLE && start) begin
        base_q     <= base;
        len_q      <= len;
        off_q      <= {15'd0, issue};
        bytes_read <= '0;
      end else begin
        if (issue) off_q <= off_q + 16'd1;
        if (pop)   bytes_read <= bytes_read + 16'd1;
      end
    end
  end

  // In-flight tracking: valid shift line and outstanding read count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      infl_q <= '0;
    end else begin
      sr_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) sr_q[i] <= sr_q[i-1];
      infl_q <= infl_q + CW'(issue) - CW'(push);
    end
  end

  // Ring buffer storage behind the head register
  always_ff @(posedge clk) begin
    if (buf_in) mem_q[wp_q] <= rd_data;
  end

  // Buffer pointers, occupancy and head register refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      head_v_q <= 1'b0;
      head_q   <= '0;
    end else begin
      if (buf_in)  wp_q <= wp_q + AW'(1);
      if (buf_out) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(buf_in) - CW'(buf_out);
      if (hd_free) begin
        if (cnt_q != '0) begin
          head_v_q <= 1'b1;
          head_q   <= mem_q[rp_q];
        end else if (push) begin
          head_v_q <= 1'b1;
          head_q   <= rd_data;
        end else begin
          head_v_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_dma_rd.sv
// tb_simple_dma_rd: directed transfers against a 2-cycle latency memory.
// Byte at address a is a[7:0] + salt.
module tb_simple_dma_rd;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] len = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready = 1'b0;
  logic [15:0] bytes_read;
  logic        busy;
  logic        done;

  simple_dma_rd #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .bytes_read(bytes_read), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] p1 = '0, p2 = '0;
  logic [7:0]  salt = '0;
  always @(posedge clk) begin
    p1 <= rd_addr;
    p2 <= p1;
  end
  assign rd_data = p2[7:0] + salt;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int s_cyc, first_v, last_hs, done_cyc;
  int n_done, n_rd, n_busy, stall_err, occ_err;
  logic       stall_pend;
  logic [7:0] stall_data;
  logic [15:0] addr_q[$];
  logic [7:0]  rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    addr_q.delete();
    rx_q.delete();
    first_v = -1; last_hs = -1; done_cyc = -1;
    n_done = 0; n_rd = 0; n_busy = 0;
    stall_err = 0; occ_err = 0; stall_pend = 1'b0;
  endtask

  // observe the current cycle at mid-cycle, then advance one cycle
  task automatic step();
    if (rd_en) begin
      addr_q.push_back(rd_addr);
      n_rd++;
    end
    if (n_rd - rx_q.size() > FIFO_DEPTH + 1) occ_err++;
    if (stall_pend && !(pix_valid && pix_data == stall_data)) stall_err++;
    stall_pend = pix_valid && !pix_ready;
    stall_data = pix_data;
    if (pix_valid && first_v < 0) first_v = cyc;
    if (pix_valid && pix_ready) begin
      rx_q.push_back(pix_data);
      last_hs = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) n_busy++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_xfer(input logic [15:0] b, input logic [15:0] l);
    clear();
    base = b;
    len = l;
    start = 1'b1;
    s_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int maxc, input bit slow);
    int k = 0;
    while (n_done == 0 && k < maxc) begin
      pix_ready = slow ? (cyc % 3 == 0) : 1'b1;
      step();
      k++;
    end
    chk({tag, "_done_seen"}, n_done, 1);
    pix_ready = 1'b1;
    step();
    step();
    chk({tag, "_one_done"}, n_done, 1);
  endtask

  task automatic check_stream(input string tag, input logic [15:0] b,
                              input int l, input logic [7:0] s);
    int err = 0;
    logic [15:0] a;
    logic [7:0] d;
    chk({tag, "_nbytes"}, rx_q.size(), l);
    chk({tag, "_nreads"}, n_rd, l);
    for (int i = 0; i < l; i++) begin
      a = b + 16'(i);
      d = a[7:0] + s;
      if (i >= rx_q.size() || rx_q[i] !== d) err++;
      if (i >= addr_q.size() || addr_q[i] !== a) err++;
    end
    chk({tag, "_order"}, err, 0);
  endtask

  initial begin
    clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_bytes_read", bytes_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();
    step();

    // 1: basic 8-byte transfer, full rate
    pix_ready = 1'b1;
    start_xfer(16'h0100, 16'd8);
    chk("t1_rd_en_s1", rd_en, 1);
    chk("t1_addr_s1", rd_addr, 16'h0100);
    chk("t1_busy_s1", busy, 1);
    run("t1", 100, 1'b0);
    chk("t1_first_valid", first_v - s_cyc, 4);
    chk("t1_last_hs", last_hs - s_cyc, 11);
    chk("t1_done_cyc", done_cyc - s_cyc, 12);
    chk("t1_bytes_read", bytes_read, 8);
    chk("t1_busy_end", busy, 0);
    check_stream("t1", 16'h0100, 8, 8'h00);

    // 2: address wrap at 0xFFFF
    start_xfer(16'hFFFE, 16'd4);
    run("t2", 100, 1'b0);
    check_stream("t2", 16'hFFFE, 4, 8'h00);
    chk("t2_bytes_read", bytes_read, 4);

    // 3: backpressure, ready 1 cycle in 3
    pix_ready = 1'b0;
    start_xfer(16'h1000, 16'd16);
    run("t3", 400, 1'b1);
    check_stream("t3", 16'h1000, 16, 8'h00);
    chk("t3_stall_stable", stall_err, 0);
    chk("t3_occupancy", occ_err, 0);
    chk("t3_done_after_last", done_cyc - last_hs, 1);
    chk("t3_bytes_read", bytes_read, 16);

    // 4: zero-length start
    start_xfer(16'h2000, 16'd0);
    chk("t4_done_s1", done, 1);
    chk("t4_busy_s1", busy, 0);
    step();
    chk("t4_done_s2", done, 0);
    chk("t4_no_reads", n_rd, 0);
    chk("t4_never_busy", n_busy, 0);
    chk("t4_bytes_read", bytes_read, 0);

    // 5: start re-pulsed mid-transfer is ignored
    start_xfer(16'h0200, 16'd8);
    step();
    step();
    step();
    base = 16'h5000;
    len = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    run("t5", 100, 1'b0);
    check_stream("t5", 16'h0200, 8, 8'h00);
    chk("t5_bytes_read", bytes_read, 8);

    // 6: reset mid-transfer, then a fresh 2-byte transfer
    start_xfer(16'h0300, 16'd10);
    for (int k = 0; k < 50 && rx_q.size() < 3; k++) step();
    chk("t6_got3", rx_q.size(), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rd_en", rd_en, 0);
    chk("t6_rst_rd_addr", rd_addr, 0);
    chk("t6_rst_pix_valid", pix_valid, 0);
    chk("t6_rst_pix_data", pix_data, 0);
    chk("t6_rst_bytes_read", bytes_read, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    @(negedge clk);
    clear();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("t6_no_done", n_done, 0);
    chk("t6_stale_dropped", rx_q.size(), 0);
    chk("t6_no_reads", n_rd, 0);
    salt = 8'h80;
    start_xfer(16'h0400, 16'd2);
    run("t6", 100, 1'b0);
    check_stream("t6", 16'h0400, 2, 8'h80);
    chk("t6_bytes_read", bytes_read, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
